instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Produces the 32-bit instruction word stream that the control unit decodes. It owns the program counter and issues in-order read requests to instruction memory.
- Buffers returned words in a 2-entry FIFO and presents each to decode with its PC over a valid/ready handshake.
- Takes the decoded branch decision (PCsel) plus target as a redirect that flushes all younger fetches.
- Sits between instruction memory and the CU/register-file stage.

Parameters:
- PC_W, 32, program counter and address width
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)
- DEPTH, 2, output FIFO entries and max outstanding requests (fixed at 2; other values unsupported)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_W  fetch address (= pc)
- imem_rsp_valid  in  1  read data valid, in request order
- imem_rsp_data  in  32  instruction word
- word  out  32  instruction to CU (opcode in [6:0])
- word_pc  out  PC_W  address of word
- word_valid  out  1  word/word_pc valid
- word_ready  in  1  decode consumes word
- redirect  in  1  taken branch (CU PCsel)
- redirect_target  in  PC_W  branch target
- err  out  1  sticky protocol error

Behaviour:
- Reset values: pc=RESET_PC; FIFO empty; inflight=0; drop_cnt=0; err=0; word_valid=0; imem_req_valid=0; word, word_pc=0.
- Outputs during the rst cycle: imem_req_valid=0 and word_valid=0.
- Request issue:
  - imem_req_valid = !rst && !redirect && (fifo_count + inflight + drop_cnt < 2).
  - imem_req_addr = pc.
  - On handshake: pc <= pc+4 (wraps modulo 2^PC_W), inflight+1, pc pushed to 2-entry address queue.
- Response:
  - drop_cnt>0: response discarded, drop_cnt-1.
  - Else if inflight>0: {data, addr-queue head} written to FIFO, inflight-1, address queue popped.
  - Else: response ignored, err<=1 (sticky until rst).
- Latency:
  - Request accepted in cycle N; response arrives in cycle M>=N+1.
  - word_valid asserts in cycle M+1. No combinational rsp->word path.
- Output handshake:
  - word_valid = FIFO non-empty; word/word_pc = FIFO head.
  - Held stable while word_valid && !word_ready.
  - Pop on word_valid && word_ready.
  - Simultaneous push and pop with FIFO full is allowed (count unchanged).
  - Push into a full FIFO cannot occur because of the issue limit.
- Redirect (sampled at the clock edge while redirect=1):
  - pc <= {redirect_target[PC_W-1:2], 2'b00}.
  - FIFO cleared; a same-cycle word handshake counts as consumed.
  - Address queue cleared; inflight <= 0.
  - drop_cnt <= drop_cnt + inflight - (1 if a response arrives this cycle, else 0).
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - First new request issues the next cycle if capacity allows.
- Back-to-back redirects: each one re-targets pc; drop accounting accumulates (bounded by 2).
- Reset mid-operation overrides everything. Instruction memory shares rst, so no responses return for pre-reset requests.
- Ordering: words leave in exact PC order between redirects; a word is never duplicated or skipped.

Test Plan:
- Reset, imem_req_ready=1, 1-cycle memory, word_ready=1 -> addresses 0x0,0x4,0x8... issued; word_pc sequence 0x0,0x4,0x8 with matching data; first word_valid 2 cycles after first request.
- word_ready=0 with 1-cycle memory -> exactly 2 words buffered (pc 0x0,0x4), imem_req_valid=0, word/word_pc stable; raise word_ready -> 0x0 then 0x4 then fetch resumes at 0x8.
- Redirect to 0x40 with 2 requests in flight (memory latency 3) -> both late responses discarded, next request addr 0x40, first word_pc after redirect = 0x40.
- Redirect to 0x103 in the same cycle as a response and a word handshake -> fetched pc 0x100, response dropped, FIFO empty next cycle, no err.
- imem_rsp_valid pulse with nothing outstanding -> err=1 and stays 1; FIFO unchanged; rst clears err.
- rst asserted mid-stream with FIFO full -> next cycle word_valid=0; first request addr = RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order fetches to instruction
// memory and hands returned words to decode through a 2-entry FIFO.
// A redirect flushes the FIFO and counts still-outstanding responses as drops.
module instr_fetch_unit #(
    parameter int unsigned          PC_W     = 32,
    parameter logic [PC_W-1:0]      RESET_PC = '0,
    parameter int unsigned          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [PC_W-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      word,
    output logic [PC_W-1:0]  word_pc,
    output logic             word_valid,
    input  logic             word_ready,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_target,
    output logic             err
);

    logic [PC_W-1:0] pc;

    // output FIFO: instruction word plus the PC it was fetched from
    logic [31:0]     fifo_data [2];
    logic [PC_W-1:0] fifo_pc   [2];
    logic            fifo_rd;
    logic            fifo_wr;
    logic [1:0]      fifo_cnt;

    // addresses of outstanding requests, oldest at aq_rd
    logic [PC_W-1:0] aq [2];
    logic            aq_rd;
    logic            aq_wr;
    logic [1:0]      inflight;

    // responses still owed by memory for requests killed by a redirect
    logic [1:0]      drop_cnt;
    logic            err_q;

    logic [2:0]      occ;
    logic            req_fire;
    logic            pop;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            rsp_orphan;
    logic            rsp_owed;
    logic            unused_target_lsb;

    // every slot (buffered, in flight or pending drop) counts against capacity,
    // which is what makes a push into a full FIFO impossible
    assign occ            = {1'b0, fifo_cnt} + {1'b0, inflight} + {1'b0, drop_cnt};
    assign imem_req_valid = !rst && !redirect && (occ < 3'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign word_valid = !rst && (fifo_cnt != 2'd0);
    assign word       = fifo_data[fifo_rd];
    assign word_pc    = fifo_pc[fifo_rd];
    assign pop        = word_valid && word_ready;
    assign err        = err_q;

    // responses are matched to requests purely by order
    assign rsp_owed   = (drop_cnt != 2'd0) || (inflight != 2'd0);
    assign rsp_drop   = imem_rsp_valid && (drop_cnt != 2'd0);
    assign rsp_keep   = imem_rsp_valid && (drop_cnt == 2'd0) && (inflight != 2'd0);
    assign rsp_orphan = imem_rsp_valid && !rsp_owed;

    // redirect targets are forced word aligned, so the low bits are ignored
    assign unused_target_lsb = ^redirect_target[1:0];

    // PC, request/response bookkeeping, FIFO and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            fifo_rd  <= 1'b0;
            fifo_wr  <= 1'b0;
            fifo_cnt <= 2'd0;
            aq_rd    <= 1'b0;
            aq_wr    <= 1'b0;
            inflight <= 2'd0;
            drop_cnt <= 2'd0;
            err_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
                aq[i]        <= '0;
            end
        end else if (redirect) begin
            // flush everything younger; the same-cycle response is one of the
            // owed ones, so it is discarded and subtracted from the debt
            pc       <= {redirect_target[PC_W-1:2], 2'b00};
            fifo_rd  <= 1'b0;
            fifo_wr  <= 1'b0;
            fifo_cnt <= 2'd0;
            aq_rd    <= 1'b0;
            aq_wr    <= 1'b0;
            inflight <= 2'd0;
            drop_cnt <= drop_cnt + inflight - 2'(imem_rsp_valid && rsp_owed);
            if (rsp_orphan) err_q <= 1'b1;
        end else begin
            if (req_fire) begin
                pc        <= pc + PC_W'(4);
                aq[aq_wr] <= pc;
                aq_wr     <= ~aq_wr;
            end
            if (rsp_keep) begin
                fifo_data[fifo_wr] <= imem_rsp_data;
                fifo_pc[fifo_wr]   <= aq[aq_rd];
                fifo_wr            <= ~fifo_wr;
                aq_rd              <= ~aq_rd;
            end
            if (pop) fifo_rd <= ~fifo_rd;
            if (rsp_drop) drop_cnt <= drop_cnt - 2'd1;
            if (rsp_orphan) err_q <= 1'b1;
            inflight <= inflight + 2'(req_fire) - 2'(rsp_keep);
            fifo_cnt <= fifo_cnt + 2'(rsp_keep) - 2'(pop);
        end
    end

endmodule
